// File: rtl/blink_remote_ctrl_pkg.sv
// Shared definitions for the UART-commanded blinker control stage:
// opcodes, FSM state encodings and the timing constants derived from
// the clock and baud rate.
package blink_remote_ctrl_pkg;

    // Command opcodes (ASCII 'E', 'M', 'P')
    localparam logic [7:0] OP_EN   = 8'h45;
    localparam logic [7:0] OP_MASK = 8'h4D;
    localparam logic [7:0] OP_PER  = 8'h50;

    // Receiver states; RX_BREAK waits for the line to go idle after a bad stop bit
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Command parser states
    typedef enum logic {
        P_OP,
        P_ARG
    } parser_state_t;

    // Derivations used by the top level for any parameter set
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned calc_ticks_10ms(input int unsigned clk_freq);
        return clk_freq / 100;
    endfunction

    function automatic int unsigned calc_default_half_cyc(input int unsigned clk_freq,
                                                          input int unsigned half_ms);
        return half_ms * (clk_freq / 1000);
    endfunction

    // Half-period for a 'P' argument: 10 ms units, an argument of 0 means 10 ms
    function automatic logic [31:0] half_from_arg(input logic [7:0]  arg,
                                                  input logic [31:0] ticks_10ms);
        logic [7:0] arg_eff;
        arg_eff = (arg == 8'd0) ? 8'd1 : arg;
        return 32'(arg_eff) * ticks_10ms;
    endfunction

    // Constants at the default 25 MHz / 115200 baud / 500 ms configuration
    localparam int unsigned CLKS_PER_BIT     = calc_clks_per_bit(25_000_000, 115_200);
    localparam int unsigned TICKS_10MS       = calc_ticks_10ms(25_000_000);
    localparam int unsigned DEFAULT_HALF_CYC = calc_default_half_cyc(25_000_000, 500);

endpackage

// File: rtl/blink_remote_ctrl_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer on rx, mid-bit sampling,
// one-cycle byte_valid on a good stop bit, one-cycle frame_err on a bad one.
module uart_rx_core
    import blink_remote_ctrl_pkg::*;
#(
    parameter int unsigned BIT_CLKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned      CNT_W    = $clog2(BIT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state,      state_next;
    logic [CNT_W-1:0] cnt,        cnt_next;
    logic [2:0]       bit_idx,    bit_next;
    logic [7:0]       shreg,      shreg_next;
    logic             valid_next;
    logic             ferr_next;

    // Synchronize rx and keep one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so the three stages shift together on one edge.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state, bit timing and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shreg      <= shreg_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

    // Next-state logic: sample mid-bit, shift LSB first, check the stop bit
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shreg_next = shreg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                    bit_next   = '0;
                end
            end
            RX_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    // Line back high at mid start bit: a glitch, not a frame
                    state_next = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        valid_next = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_BREAK;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_BREAK: begin
                if (rx_sync) begin
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/blink_remote_ctrl.sv
// UART-commanded configuration for the LED blinker: decodes 2-byte
// (opcode, argument) commands and owns half_period, blink_en and led_mask.
module blink_remote_ctrl
    import blink_remote_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 25_000_000,
    parameter int unsigned BAUD            = 115_200,
    parameter int unsigned DEFAULT_HALF_MS = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] half_period,
    output logic        blink_en,
    output logic [7:0]  led_mask,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic        frame_err
);

    localparam int unsigned BIT_CLKS       = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] TMO_TICKS      = 32'(calc_ticks_10ms(CLK_FREQ));
    localparam logic [31:0] RESET_HALF_CYC = 32'(calc_default_half_cyc(CLK_FREQ, DEFAULT_HALF_MS));

    logic [7:0]    byte_data;
    logic          byte_valid;
    parser_state_t p_state, p_next;
    logic [7:0]    op_reg,  op_next;
    logic [31:0]   tmo_cnt, tmo_next;
    logic [31:0]   hp_next;
    logic          en_next;
    logic [7:0]    mask_next;
    logic          valid_next;
    logic          err_next;

    uart_rx_core #(
        .BIT_CLKS (BIT_CLKS)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Parser state, timeout counter and blinker configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state     <= P_OP;
            op_reg      <= '0;
            tmo_cnt     <= '0;
            half_period <= RESET_HALF_CYC;
            blink_en    <= 1'b1;
            led_mask    <= 8'h01;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            p_state     <= p_next;
            op_reg      <= op_next;
            tmo_cnt     <= tmo_next;
            half_period <= hp_next;
            blink_en    <= en_next;
            led_mask    <= mask_next;
            cmd_valid   <= valid_next;
            cmd_err     <= err_next;
        end
    end

    // Opcode/argument sequencing; a received argument takes priority over the timeout
    always_comb begin
        p_next     = p_state;
        op_next    = op_reg;
        tmo_next   = tmo_cnt;
        hp_next    = half_period;
        en_next    = blink_en;
        mask_next  = led_mask;
        valid_next = 1'b0;
        err_next   = 1'b0;
        unique case (p_state)
            P_OP: begin
                if (byte_valid) begin
                    op_next  = byte_data;
                    tmo_next = '0;
                    p_next   = P_ARG;
                end
            end
            P_ARG: begin
                if (byte_valid) begin
                    p_next     = P_OP;
                    valid_next = 1'b1;
                    case (op_reg)
                        OP_EN:   en_next   = byte_data[0];
                        OP_MASK: mask_next = byte_data;
                        OP_PER:  hp_next   = half_from_arg(byte_data, TMO_TICKS);
                        default: begin
                            // Unknown opcode: argument consumed, nothing applied
                            valid_next = 1'b0;
                            err_next   = 1'b1;
                        end
                    endcase
                end else if (tmo_cnt == TMO_TICKS - 32'd1) begin
                    err_next = 1'b1;
                    p_next   = P_OP;
                end else begin
                    tmo_next = tmo_cnt + 32'd1;
                end
            end
            default: p_next = P_OP;
        endcase
    end

endmodule

// File: tb/tb_blink_remote_ctrl.sv
// Directed bench for blink_remote_ctrl at 1 MHz / 100 kbaud: expected
// command outcomes are queued as frames are sent and compared whenever
// the DUT pulses cmd_valid, cmd_err or frame_err.
module tb_blink_remote_ctrl;

    localparam int unsigned CPB = 10;

    typedef struct {
        logic [2:0]  kind;   // {cmd_valid, cmd_err, frame_err}
        logic [31:0] hp;
        logic        en;
        logic [7:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [31:0] half_period;
    logic        blink_en;
    logic [7:0]  led_mask;
    logic        cmd_valid;
    logic        cmd_err;
    logic        frame_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Reference model of the configuration registers
    logic [31:0] m_hp   = 32'd500_000;
    logic        m_en   = 1'b1;
    logic [7:0]  m_mask = 8'h01;

    blink_remote_ctrl #(
        .CLK_FREQ        (1_000_000),
        .BAUD            (100_000),
        .DEFAULT_HALF_MS (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .half_period (half_period),
        .blink_en    (blink_en),
        .led_mask    (led_mask),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.hp   = m_hp;
        e.en   = m_en;
        e.mask = m_mask;
        exp_q.push_back(e);
    endtask

    // One 8N1 frame with a selectable stop-bit level, followed by one idle bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit plus the first nbits data bits, frame left unfinished
    task automatic send_partial(input logic [7:0] b, input int nbits);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Update the model, queue the expected outcome, then send both bytes
    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg);
        logic [2:0] kind;
        kind = 3'b100;
        case (op)
            8'h45: m_en = arg[0];
            8'h4D: m_mask = arg;
            8'h50: m_hp = (arg == 8'd0) ? 32'd10_000 : 32'(arg) * 32'd10_000;
            default: kind = 3'b010;
        endcase
        push_exp(kind);
        send_byte(op, 1'b1);
        send_byte(arg, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hp"},   half_period, 32'd500_000);
        check({tag, "_en"},   32'(blink_en), 32'd1);
        check({tag, "_mask"}, 32'(led_mask), 32'h01);
        check({tag, "_puls"}, 32'({cmd_valid, cmd_err, frame_err}), 32'd0);
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (cmd_valid || cmd_err || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({cmd_valid, cmd_err, frame_err}), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", 32'({cmd_valid, cmd_err, frame_err}), 32'(e.kind));
                check("half_period", half_period, e.hp);
                check("blink_en", 32'(blink_en), 32'(e.en));
                check("led_mask", 32'(led_mask), 32'(e.mask));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");
        repeat (50) @(negedge clk);
        check_reset_state("idle");

        // Half-period commands, including the zero clamp
        send_cmd(8'h50, 8'h05);
        wait_drain("per5_drain", 200);
        check("per5_hp", half_period, 32'd50_000);
        send_cmd(8'h50, 8'h00);
        wait_drain("per0_drain", 200);
        check("per0_hp", half_period, 32'd10_000);

        // Mask and enable
        send_cmd(8'h4D, 8'hA5);
        send_cmd(8'h45, 8'h00);
        wait_drain("mask_en_drain", 200);
        check("mask_a5", 32'(led_mask), 32'hA5);
        check("en_0", 32'(blink_en), 32'd0);

        // Unknown opcode
        send_cmd(8'h33, 8'h01);
        wait_drain("unk_drain", 200);

        // Lone opcode times out after 10 ms, then a normal command works
        push_exp(3'b010);
        send_byte(8'h50, 1'b1);
        repeat (9_900) @(negedge clk);
        check("tmo_not_early", exp_q.size(), 1);
        wait_drain("tmo_drain", 400);
        send_cmd(8'h4D, 8'h0F);
        wait_drain("after_tmo_drain", 200);
        check("mask_0f", 32'(led_mask), 32'h0F);

        // Bad stop bit: frame_err only, parser stays waiting for an opcode
        push_exp(3'b001);
        send_byte(8'h4D, 1'b0);
        wait_drain("ferr_drain", 200);
        send_cmd(8'h45, 8'h01);
        wait_drain("after_ferr_drain", 200);
        check("en_1", 32'(blink_en), 32'd1);

        // Short low glitch is rejected as a false start
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        send_cmd(8'h4D, 8'h81);
        wait_drain("after_glitch_drain", 200);
        check("mask_81", 32'(led_mask), 32'h81);

        // Reset in the middle of an argument byte
        send_byte(8'h4D, 1'b1);
        send_partial(8'h77, 4);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_hp   = 32'd500_000;
        m_en   = 1'b1;
        m_mask = 8'h01;
        @(negedge clk);
        check_reset_state("midreset");
        repeat (30) @(negedge clk);
        send_cmd(8'h4D, 8'h3C);
        wait_drain("after_rst_drain", 200);
        check("mask_3c", 32'(led_mask), 32'h3C);
        check("hp_after_rst", half_period, 32'd500_000);

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
